// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage request controller: sequential PC generation, single-outstanding SRAM-like
// instruction reads, one-entry output buffer towards ID, and redirect squashing.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [3:0]  inst_wstrb,
    output logic [31:0] inst_wdata,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic        r_redir_pend;
    logic        r_inst_req;
    logic [31:0] r_inst_addr;
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic [31:0] r_fs_inst;
    logic        r_fs_adef;

    logic        w_launch;
    logic [31:0] w_launch_pc;
    logic        w_misaligned;

    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // Decide whether this cycle starts a new fetch (entry to REQ) and from which PC.
    always_comb begin
        w_launch    = 1'b0;
        w_launch_pc = r_pc;
        case (r_state)
            ST_BOOT: begin
                w_launch    = 1'b1;
                w_launch_pc = flush ? flush_pc : r_pc;
            end
            ST_REQ: begin
                if (w_misaligned && flush) begin
                    w_launch    = 1'b1;
                    w_launch_pc = flush_pc;
                end else begin
                    w_launch    = 1'b0;
                end
            end
            ST_WAIT: begin
                if (flush && inst_data_ok) begin
                    w_launch    = 1'b1;
                    w_launch_pc = flush_pc;
                end else begin
                    w_launch    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_launch    = 1'b1;
                    w_launch_pc = flush_pc;
                end else if (id_allowin) begin
                    w_launch    = 1'b1;
                    w_launch_pc = r_pc + 32'd4;
                end else begin
                    w_launch    = 1'b0;
                end
            end
            ST_DISCARD: begin
                if (inst_data_ok) begin
                    w_launch    = 1'b1;
                    w_launch_pc = flush ? flush_pc : r_redir_pc;
                end else begin
                    w_launch    = 1'b0;
                end
            end
            default: begin
                w_launch    = 1'b0;
            end
        endcase
    end

    // Fetch FSM with all bus and ID-facing outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_redir_pc   <= 32'h0000_0000;
            r_redir_pend <= 1'b0;
            r_inst_req   <= 1'b0;
            r_inst_addr  <= RESET_PC;
            r_fs_valid   <= 1'b0;
            r_fs_pc      <= RESET_PC;
            r_fs_inst    <= 32'h0000_0000;
            r_fs_adef    <= 1'b0;
        end else if (w_launch) begin
            // A misaligned target enters REQ without raising a bus request.
            r_state      <= ST_REQ;
            r_pc         <= w_launch_pc;
            r_inst_addr  <= w_launch_pc;
            r_inst_req   <= (w_launch_pc[1:0] == 2'b00);
            r_redir_pend <= 1'b0;
            r_fs_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_misaligned) begin
                        r_state    <= ST_HOLD;
                        r_fs_valid <= 1'b1;
                        r_fs_pc    <= r_pc;
                        r_fs_inst  <= 32'h0000_0000;
                        r_fs_adef  <= 1'b1;
                    end else if (inst_addr_ok) begin
                        r_inst_req   <= 1'b0;
                        r_redir_pend <= 1'b0;
                        r_state      <= (flush || r_redir_pend) ? ST_DISCARD : ST_WAIT;
                        if (flush) begin
                            r_redir_pc <= flush_pc;
                        end else begin
                            r_redir_pc <= r_redir_pc;
                        end
                    end else if (flush) begin
                        r_redir_pc   <= flush_pc;
                        r_redir_pend <= 1'b1;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        r_redir_pc <= flush_pc;
                        r_state    <= ST_DISCARD;
                    end else if (inst_data_ok) begin
                        r_state    <= ST_HOLD;
                        r_fs_valid <= 1'b1;
                        r_fs_pc    <= r_pc;
                        r_fs_inst  <= inst_rdata;
                        r_fs_adef  <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (flush) begin
                        r_redir_pc <= flush_pc;
                    end else begin
                        r_redir_pc <= r_redir_pc;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign inst_req       = r_inst_req;
    assign inst_addr      = r_inst_addr;
    assign inst_wr        = 1'b0;
    assign inst_size      = 2'b10;
    assign inst_wstrb     = 4'b0000;
    assign inst_wdata     = 32'h0000_0000;
    assign fs_to_ds_valid = r_fs_valid;
    assign fs_pc          = r_fs_pc;
    assign fs_inst        = r_fs_inst;
    assign fs_adef        = r_fs_adef;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: scripted SRAM-like slave, scoreboard of offered
// instructions, and directed redirect/misalignment/wrap scenarios.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    inst_fetch_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .id_allowin     (id_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst),
        .fs_adef        (fs_adef),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_wstrb     (inst_wstrb),
        .inst_wdata     (inst_wdata),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Slave: wait for a request, accept it, return rd after gap idle cycles.
    task automatic bus_fetch(input logic [31:0] exp_addr, input logic [31:0] rd, input int gap);
        for (int i = 0; i < 20 && inst_req !== 1'b1; i++) tick();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL bus_req: req=%b addr=%h required req=1 addr=%h", inst_req, inst_addr, exp_addr);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        repeat (gap) tick();
        inst_data_ok = 1'b1;
        inst_rdata   = rd;
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
    endtask

    // ID side: wait for a valid offer, compare with the scoreboard head, then accept it.
    task automatic accept();
        exp_t e;
        for (int i = 0; i < 20 && fs_to_ds_valid !== 1'b1; i++) tick();
        n_checks++;
        if (fs_to_ds_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL accept_valid: valid=%b queued=%0d required valid=1 with an entry",
                     fs_to_ds_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (fs_pc !== e.pc || fs_inst !== e.inst || fs_adef !== e.adef) begin
                n_fail++;
                $display("FAIL accept_data: pc=%h inst=%h adef=%b required pc=%h inst=%h adef=%b",
                         fs_pc, fs_inst, fs_adef, e.pc, e.inst, e.adef);
            end
        end
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (inst_req !== 1'b0 || inst_addr !== 32'h1c00_0000 || fs_to_ds_valid !== 1'b0 ||
            fs_pc !== 32'h1c00_0000 || fs_inst !== 32'h0 || fs_adef !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: req=%b addr=%h valid=%b pc=%h inst=%h adef=%b required 0/1c000000/0/1c000000/0/0",
                     inst_req, inst_addr, fs_to_ds_valid, fs_pc, fs_inst, fs_adef);
        end
        n_checks++;
        if (inst_wr !== 1'b0 || inst_size !== 2'b10 || inst_wstrb !== 4'b0000 || inst_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL tied_outs: wr=%b size=%b wstrb=%b wdata=%h required 0/10/0000/0",
                     inst_wr, inst_size, inst_wstrb, inst_wdata);
        end
        resetn = 1'b1;
        tick();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h required 1/1c000000", inst_req, inst_addr);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back('{pc: 32'h1c00_0000, inst: 32'h0280_0421, adef: 1'b0});
        bus_fetch(32'h1c00_0000, 32'h0280_0421, 1);
        accept();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0004 || fs_to_ds_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL next_seq: req=%b addr=%h valid=%b required 1/1c000004/0",
                     inst_req, inst_addr, fs_to_ds_valid);
        end
    endtask

    task automatic test_hold_stall();
        exp_q.push_back('{pc: 32'h1c00_0004, inst: 32'h1111_2222, adef: 1'b0});
        bus_fetch(32'h1c00_0004, 32'h1111_2222, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (fs_to_ds_valid !== 1'b1 || fs_inst !== 32'h1111_2222 || fs_pc !== 32'h1c00_0004 || inst_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stall[%0d]: valid=%b inst=%h pc=%h req=%b required 1/11112222/1c000004/0",
                         i, fs_to_ds_valid, fs_inst, fs_pc, inst_req);
            end
            tick();
        end
        accept();
        n_checks++;
        if (inst_addr !== 32'h1c00_0008) begin
            n_fail++;
            $display("FAIL hold_next: addr=%h required 1c000008", inst_addr);
        end
    endtask

    task automatic test_flush_wait();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c00_0100;
        tick();
        flush = 1'b0;
        tick(); tick();
        n_checks++;
        if (inst_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_idle: req=%b valid=%b required 0/0", inst_req, fs_to_ds_valid);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        tick();
        inst_data_ok = 1'b0; inst_rdata = 32'h0;
        n_checks++;
        if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c00_0100) begin
            n_fail++;
            $display("FAIL flush_wait: valid=%b req=%b addr=%h required 0/1/1c000100",
                     fs_to_ds_valid, inst_req, inst_addr);
        end
        exp_q.push_back('{pc: 32'h1c00_0100, inst: 32'h0abc_0001, adef: 1'b0});
        bus_fetch(32'h1c00_0100, 32'h0abc_0001, 2);
        accept();
    endtask

    task automatic test_flush_req();
        flush = 1'b1; flush_pc = 32'h1c00_0200;
        tick();
        flush = 1'b0;
        tick();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0104) begin
            n_fail++;
            $display("FAIL flush_req_stable: req=%b addr=%h required 1/1c000104", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
        tick();
        inst_data_ok = 1'b0;
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0200 || fs_to_ds_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_redir: req=%b addr=%h valid=%b required 1/1c000200/0",
                     inst_req, inst_addr, fs_to_ds_valid);
        end
    endtask

    task automatic test_misaligned();
        bus_fetch(32'h1c00_0200, 32'h7777_0000, 0);
        flush = 1'b1; flush_pc = 32'h1c00_0102; id_allowin = 1'b1;
        tick();
        flush = 1'b0; id_allowin = 1'b0;
        n_checks++;
        if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_flush: valid=%b req=%b required 0/0", fs_to_ds_valid, inst_req);
        end
        tick();
        n_checks++;
        if (fs_to_ds_valid !== 1'b1 || inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL adef_offer: valid=%b req=%b required 1/0", fs_to_ds_valid, inst_req);
        end
        exp_q.push_back('{pc: 32'h1c00_0102, inst: 32'h0, adef: 1'b1});
        accept();
    endtask

    task automatic test_back_to_back_flush();
        // pc is now 1c000106 (still misaligned); redirect from its HOLD to an aligned target
        for (int i = 0; i < 5 && fs_to_ds_valid !== 1'b1; i++) tick();
        flush = 1'b1; flush_pc = 32'h1c00_0400;
        tick();
        flush = 1'b0;
        bus_fetch(32'h1c00_0400, 32'h0, 0);
        // bus_fetch leaves the design in HOLD; squash that word and start a fresh fetch
        flush = 1'b1; flush_pc = 32'h1c00_0500;
        tick();
        flush = 1'b0;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c00_0200;
        tick();
        flush_pc = 32'h1c00_0300;
        tick();
        flush = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h9999_9999;
        tick();
        inst_data_ok = 1'b0;
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0300 || fs_to_ds_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL double_flush: req=%b addr=%h valid=%b required 1/1c000300/0",
                     inst_req, inst_addr, fs_to_ds_valid);
        end
        exp_q.push_back('{pc: 32'h1c00_0300, inst: 32'h0303_0303, adef: 1'b0});
        bus_fetch(32'h1c00_0300, 32'h0303_0303, 1);
        accept();
    endtask

    task automatic test_wrap_and_reset();
        bus_fetch(32'h1c00_0304, 32'h0, 0);
        flush = 1'b1; flush_pc = 32'hffff_fffc;
        tick();
        flush = 1'b0;
        exp_q.push_back('{pc: 32'hffff_fffc, inst: 32'h0bad_cafe, adef: 1'b0});
        bus_fetch(32'hffff_fffc, 32'h0bad_cafe, 0);
        accept();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL pc_wrap: req=%b addr=%h required 1/00000000", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (inst_req !== 1'b0 || inst_addr !== 32'h1c00_0000 || fs_to_ds_valid !== 1'b0 || fs_pc !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL mid_reset: req=%b addr=%h valid=%b pc=%h required 0/1c000000/0/1c000000",
                     inst_req, inst_addr, fs_to_ds_valid, fs_pc);
        end
        tick();
        resetn = 1'b1;
        tick();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL reset_restart: req=%b addr=%h required 1/1c000000", inst_req, inst_addr);
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; flush_pc = 32'h0; id_allowin = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        test_reset();
        test_basic();
        test_hold_stall();
        test_flush_wait();
        test_flush_req();
        test_misaligned();
        test_back_to_back_flush();
        test_wrap_and_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
